clock_set_ctrl: RTL and testbench

- Time-set controller for the digital clock.
- Takes two raw push-buttons (mode, increment) and sequences the timekeeping counter through RUN, hour-edit and minute-edit.
- Loads the edited hour/minute into the counter and drives a digit-blink mask to the seven-segment unit.
- Sits between the board buttons and the time-of-day counter / display driver in the top level.

---
 rtl/clock_set_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Time-set controller for the digital clock. Conditions two raw push-buttons
// (synchronize, debounce, rising-edge detect) and steps the clock through
// RUN -> SET_HR -> SET_MIN -> COMMIT. In COMMIT it pulses `load` so the
// time-of-day counter takes the edited hour/minute. It also drives a
// digit-blink mask for the display driver.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   btn_mode   in   raw mode button (asynchronous, active high)
//   btn_inc    in   raw increment button (asynchronous, active high)
//   cur_hr     in   current hour 0..23 from the time counter
//   cur_min    in   current minute 0..59 from the time counter
//   run_en     out  time counter advances while high
//   load       out  one-cycle strobe: counter takes load_hr/load_min
//   load_hr    out  hour to load, held until the next commit
//   load_min   out  minute to load, held until the next commit
//   blink_mask out  1 = blank digit; [3:2] hour digits, [1:0] minute digits
//   mode       out  state code RUN=00 SET_HR=01 SET_MIN=10 COMMIT=11
//
// Build option: define CLOCK_SET_AUTOREPEAT_EN to make a held increment button
// generate a further increment every REPEAT_CYCLES cycles in the set states.
// Without it, each press gives exactly one increment.
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int DB_CYCLES     = 500000,
    parameter int BLINK_CYCLES  = 25000000,
    parameter int REPEAT_CYCLES = 30000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    output logic       run_en,
    output logic       load,
    output logic [4:0] load_hr,
    output logic [5:0] load_min,
    output logic [3:0] blink_mask,
    output logic [1:0] mode
);

    if (DB_CYCLES < 1 || BLINK_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("clock_set_ctrl: cycle-count parameters must be positive");
    end

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10,
        ST_COMMIT  = 2'b11
    } state_t;

    // ---------------------------------------------------------------------
    // Button conditioning; bit 0 = mode, bit 1 = inc
    // ---------------------------------------------------------------------
    logic [1:0]      w_btn_raw;
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_db;
    logic [1:0]      r_db_d;
    logic [1:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [2];

    assign w_btn_raw = {btn_inc, btn_mode};

    // The counter runs 0..DB_CYCLES while the synchronized level disagrees,
    // so a raw edge sampled at edge t moves the debounced level at
    // t+2+DB_CYCLES; the registered edge detect adds one more cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            r_press <= '0;
            // NOTE: r_db_cnt is a tiny flop array, not a RAM, so it is reset like any register.
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DB_CYCLES)) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_mode_press;
    logic            w_rep_pulse;
    logic            w_in_set;
    logic            w_set_entry;
    logic            w_inc_acc;
    logic [4:0]      r_edit_hr;
    logic [5:0]      r_edit_min;
    logic [4:0]      r_load_hr;
    logic [5:0]      r_load_min;
    logic [BL_W-1:0] r_blink_cnt;
    logic            r_phase;

    assign w_mode_press = r_press[0];
    assign w_in_set     = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);
    assign w_set_entry  = (w_state_nxt != r_state) &&
                          ((w_state_nxt == ST_SET_HR) || (w_state_nxt == ST_SET_MIN));
    // A mode press in the same cycle swallows any increment.
    assign w_inc_acc    = w_in_set && (r_press[1] || w_rep_pulse) && !w_mode_press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        run_en      = 1'b1;
        load        = 1'b0;
        blink_mask  = 4'b0000;
        unique case (r_state)
            ST_RUN: begin
                if (w_mode_press) w_state_nxt = ST_SET_HR;
            end
            ST_SET_HR: begin
                run_en     = 1'b0;
                blink_mask = r_phase ? 4'b1100 : 4'b0000;
                if (w_mode_press) w_state_nxt = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                run_en     = 1'b0;
                blink_mask = r_phase ? 4'b0011 : 4'b0000;
                if (w_mode_press) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                run_en      = 1'b0;
                load        = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign mode     = r_state;
    assign load_hr  = r_load_hr;
    assign load_min = r_load_min;

    // Edit values are captured on leaving RUN; the load registers are
    // captured on entering COMMIT so they are valid during the strobe and
    // hold afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edit_hr  <= '0;
            r_edit_min <= '0;
            r_load_hr  <= '0;
            r_load_min <= '0;
        end else begin
            if (r_state == ST_RUN && w_mode_press) begin
                r_edit_hr  <= cur_hr;
                r_edit_min <= cur_min;
            end else if (w_inc_acc && r_state == ST_SET_HR) begin
                r_edit_hr  <= (r_edit_hr == 5'd23) ? 5'd0 : r_edit_hr + 5'd1;
            end else if (w_inc_acc && r_state == ST_SET_MIN) begin
                r_edit_min <= (r_edit_min == 6'd59) ? 6'd0 : r_edit_min + 6'd1;
            end
            if (r_state == ST_SET_MIN && w_mode_press) begin
                r_load_hr  <= r_edit_hr;
                r_load_min <= r_edit_min;
            end
        end
    end

    // Blink phase restarts visible on set-state entry and on every accepted
    // increment so the user sees the new value immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (!w_in_set || w_set_entry || w_inc_acc) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BL_W'(1);
        end
    end

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0] r_rep_cnt;

    // Counter restarts on the real press, so repeats land REPEAT_CYCLES
    // after it and every REPEAT_CYCLES thereafter while the level stays high.
    assign w_rep_pulse = w_in_set && r_db[1] &&
                         (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt <= '0;
        end else if (!w_in_set || !r_db[1] || r_press[1] || w_rep_pulse ||
                     (w_state_nxt != r_state)) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
    end
`else
    assign w_rep_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Self-checking bench for clock_set_ctrl with DB_CYCLES=4, BLINK_CYCLES=8,
// REPEAT_CYCLES=10. Expected load values are queued before each committing
// mode press and compared by a monitor whenever the DUT strobes `load`.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int DB = 4;
    localparam int BL = 8;
    localparam int RP = 10;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [4:0] cur_hr   = 5'd0;
    logic [5:0] cur_min  = 6'd0;
    logic       run_en;
    logic       load;
    logic [4:0] load_hr;
    logic [5:0] load_min;
    logic [3:0] blink_mask;
    logic [1:0] mode;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] min;
    } load_exp_t;

    load_exp_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_loads  = 0;

    clock_set_ctrl #(
        .DB_CYCLES    (DB),
        .BLINK_CYCLES (BL),
        .REPEAT_CYCLES(RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_hr    (cur_hr),
        .cur_min   (cur_min),
        .run_en    (run_en),
        .load      (load),
        .load_hr   (load_hr),
        .load_min  (load_min),
        .blink_mask(blink_mask),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    // Scoreboard: every load strobe must match the oldest queued commit.
    always @(negedge clk) begin
        if (rst === 1'b1 && load === 1'b1) begin
            load_exp_t e;
            n_loads++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_load: got load_hr=%0d load_min=%0d, expected no load",
                         load_hr, load_min);
            end else begin
                e = exp_q.pop_front();
                if (load_hr !== e.hr || load_min !== e.min) begin
                    n_errors++;
                    $display("FAIL load_value: got %0d:%0d, expected %0d:%0d",
                             load_hr, load_min, e.hr, e.min);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Raw press: high for `hold` sampled edges, then released. Returns #1
    // after edge t+hold-1 where t is the first edge that samples it high.
    task automatic start_press(input logic m, input logic i, input int hold);
        @(posedge clk);
        #1;
        btn_mode = m;
        btn_inc  = i;
        repeat (hold) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic press(input logic m, input logic i);
        start_press(m, i, 6);
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] exp_rst;
        logic [18:0] got;
        exp_rst = {2'b00, 1'b1, 1'b0, 5'd0, 6'd0, 4'd0};
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = {mode, run_en, load, load_hr, load_min, blink_mask};
        n_checks++;
        if (got !== exp_rst) begin
            n_errors++;
            $display("FAIL reset_initial: got %h, expected %h", got, exp_rst);
        end
        rst = 1'b1;
        cur_hr  = 5'd9;
        cur_min = 6'd15;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        n_checks++;
        if (mode !== 2'b10 || run_en !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_reach_set_min: got mode=%b run_en=%b, expected 10/0", mode, run_en);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        got = {mode, run_en, load, load_hr, load_min, blink_mask};
        n_checks++;
        if (got !== exp_rst) begin
            n_errors++;
            $display("FAIL reset_async_mid_edit: got %h, expected %h", got, exp_rst);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        got = {mode, run_en, load, load_hr, load_min, blink_mask};
        n_checks++;
        if (got !== exp_rst) begin
            n_errors++;
            $display("FAIL reset_after_release: got %h, expected %h", got, exp_rst);
        end
    endtask

    task automatic test_debounce();
        cur_hr  = 5'd7;
        cur_min = 6'd30;
        start_press(1'b1, 1'b0, 3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mode !== 2'b00) begin
            n_errors++;
            $display("FAIL debounce_glitch: got mode=%b, expected 00", mode);
        end
        start_press(1'b1, 1'b0, 5);
        for (int k = 5; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 7) begin
                n_checks++;
                if (mode !== 2'b00) begin
                    n_errors++;
                    $display("FAIL debounce_early: got mode=%b at edge+7, expected 00", mode);
                end
            end else if (k == 8) begin
                n_checks++;
                if (mode !== 2'b01) begin
                    n_errors++;
                    $display("FAIL debounce_latency: got mode=%b at edge+8, expected 01", mode);
                end
            end
        end
        repeat (16) @(posedge clk);
        #1;
        press(1'b1, 1'b0);
        exp_q.push_back('{hr: 5'd7, min: 6'd30});
        press(1'b1, 1'b0);
    endtask

    task automatic test_full_edit();
        bit found;
        cur_hr  = 5'd22;
        cur_min = 6'd58;
        press(1'b1, 1'b0);
        n_checks++;
        if (mode !== 2'b01 || run_en !== 1'b0 || load !== 1'b0) begin
            n_errors++;
            $display("FAIL edit_enter_set_hr: got mode=%b run_en=%b load=%b, expected 01/0/0",
                     mode, run_en, load);
        end
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        n_checks++;
        if (mode !== 2'b10 || run_en !== 1'b0) begin
            n_errors++;
            $display("FAIL edit_enter_set_min: got mode=%b run_en=%b, expected 10/0", mode, run_en);
        end
        repeat (3) press(1'b0, 1'b1);
        exp_q.push_back('{hr: 5'd0, min: 6'd1});
        start_press(1'b1, 1'b0, 6);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (load === 1'b1) begin
                found = 1'b1;
                n_checks++;
                if (mode !== 2'b11 || run_en !== 1'b0) begin
                    n_errors++;
                    $display("FAIL commit_cycle: got mode=%b run_en=%b, expected 11/0", mode, run_en);
                end
                @(negedge clk);
                n_checks++;
                if (mode !== 2'b00 || run_en !== 1'b1 || load !== 1'b0) begin
                    n_errors++;
                    $display("FAIL after_commit: got mode=%b run_en=%b load=%b, expected 00/1/0",
                             mode, run_en, load);
                end
            end
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL commit_timeout: got no load within 20 cycles, expected one");
        end
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (load_hr !== 5'd0 || load_min !== 6'd1) begin
            n_errors++;
            $display("FAIL load_hold: got %0d:%0d, expected 0:1", load_hr, load_min);
        end
    endtask

    task automatic test_simultaneous();
        cur_hr  = 5'd5;
        cur_min = 6'd10;
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        n_checks++;
        if (mode !== 2'b10) begin
            n_errors++;
            $display("FAIL simultaneous_mode_wins: got mode=%b, expected 10", mode);
        end
        exp_q.push_back('{hr: 5'd5, min: 6'd10});
        press(1'b1, 1'b0);
        n_checks++;
        if (mode !== 2'b00) begin
            n_errors++;
            $display("FAIL simultaneous_back_to_run: got mode=%b, expected 00", mode);
        end
    endtask

    task automatic test_blink();
        bit       entered;
        logic [3:0] exp_mask;
        cur_hr  = 5'd3;
        cur_min = 6'd4;
        start_press(1'b1, 1'b0, 6);
        entered = 1'b0;
        for (int k = 6; k < 40 && !entered; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mode === 2'b01) entered = 1'b1;
        end
        n_checks++;
        if (!entered) begin
            n_errors++;
            $display("FAIL blink_enter_hr: got mode=%b, expected 01 within bound", mode);
        end
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            exp_mask = ((i / BL) % 2 == 1) ? 4'b1100 : 4'b0000;
            n_checks++;
            if (blink_mask !== exp_mask) begin
                n_errors++;
                $display("FAIL blink_hr[%0d]: got %b, expected %b", i, blink_mask, exp_mask);
            end
        end
        start_press(1'b0, 1'b1, 6);
        for (int k = 6; k < 24; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= 8) begin
                exp_mask = (k >= 16) ? 4'b1100 : 4'b0000;
                n_checks++;
                if (blink_mask !== exp_mask) begin
                    n_errors++;
                    $display("FAIL blink_inc_restart[%0d]: got %b, expected %b", k, blink_mask, exp_mask);
                end
            end
        end
        start_press(1'b1, 1'b0, 6);
        entered = 1'b0;
        for (int k = 6; k < 40 && !entered; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mode === 2'b10) entered = 1'b1;
        end
        n_checks++;
        if (!entered) begin
            n_errors++;
            $display("FAIL blink_enter_min: got mode=%b, expected 10 within bound", mode);
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            exp_mask = (i >= BL) ? 4'b0011 : 4'b0000;
            n_checks++;
            if (blink_mask !== exp_mask) begin
                n_errors++;
                $display("FAIL blink_min[%0d]: got %b, expected %b", i, blink_mask, exp_mask);
            end
        end
        exp_q.push_back('{hr: 5'd4, min: 6'd4});
        press(1'b1, 1'b0);
    endtask

    task automatic test_autorepeat();
        cur_hr  = 5'd12;
        cur_min = 6'd57;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        @(posedge clk);
        #1;
        btn_inc = 1'b1;
        repeat (36) @(posedge clk);
        #1;
        btn_inc = 1'b0;
        repeat (16) @(posedge clk);
        #1;
`ifdef CLOCK_SET_AUTOREPEAT_EN
        exp_q.push_back('{hr: 5'd12, min: 6'd1});
`else
        exp_q.push_back('{hr: 5'd12, min: 6'd58});
`endif
        press(1'b1, 1'b0);
        n_checks++;
        if (mode !== 2'b00 || run_en !== 1'b1) begin
            n_errors++;
            $display("FAIL autorepeat_back_to_run: got mode=%b run_en=%b, expected 00/1", mode, run_en);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_full_edit();
        test_simultaneous();
        test_blink();
        test_autorepeat();
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || n_loads != 5) begin
            n_errors++;
            $display("FAIL load_count: got %0d loads with %0d pending, expected 5 loads with 0 pending",
                     n_loads, exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
